// File: rtl/sram_arb2.sv
// sram_arb2: round-robin two-client arbiter and command sequencer for a 32768x96 single-port SRAM.
// Defining SRAM_ARB_INIT_EN adds a post-reset sweep that writes zero to every word before grants open.
module sram_arb2 #(
   parameter int ADDRW = 15,
   parameter int WORDW = 96,
   parameter int DEPTH = 32768
) (
   input  logic             iClk,
   input  logic             iRstn,
   input  logic             iReqA,
   input  logic             iReqB,
   input  logic             iWrA,
   input  logic             iWrB,
   input  logic [ADDRW-1:0] iAddrA,
   input  logic [ADDRW-1:0] iAddrB,
   input  logic [WORDW-1:0] iDinA,
   input  logic [WORDW-1:0] iDinB,
   output logic             oGntA,
   output logic             oGntB,
   output logic             oRvalidA,
   output logic             oRvalidB,
   output logic [WORDW-1:0] oRdata,
   output logic             oInitDone,
   output logic             oNCE,
   output logic             oNWRT,
   output logic [10:0]      oRA,
   output logic [3:0]       oCA,
   output logic [WORDW-1:0] oDIN,
   input  logic [WORDW-1:0] iDO
);

   logic [1:0]            req;
   logic [1:0]            wr;
   logic [1:0]            gnt;
   logic [1:0]            rvalid;
   logic [1:0][ADDRW-1:0] addr_sel;
   logic [1:0][WORDW-1:0] din_sel;
   logic                  sel;
   logic                  accept;
   logic                  run;
   logic                  init_active;
   logic [ADDRW-1:0]      clr_addr;

   logic                  last_reg;   // 1 = client B was granted most recently
   logic                  last_next;
   logic                  nce_reg;
   logic                  nce_next;
   logic                  nwrt_reg;
   logic                  nwrt_next;
   logic [ADDRW-1:0]      addr_reg;
   logic [ADDRW-1:0]      addr_next;
   logic [WORDW-1:0]      din_reg;
   logic [WORDW-1:0]      din_next;

   assign req      = {iReqB, iReqA};
   assign wr       = {iWrB, iWrA};
   assign addr_sel = {iAddrB, iAddrA};
   assign din_sel  = {iDinB, iDinA};

`ifdef SRAM_ARB_INIT_EN
   localparam logic [0:0]       ST_INIT   = 1'b0;
   localparam logic [0:0]       ST_RUN    = 1'b1;
   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

   logic [0:0]       state_reg;
   logic [0:0]       state_next;
   logic [ADDRW-1:0] clr_cnt_reg;
   logic [ADDRW-1:0] clr_cnt_next;

   assign init_active = (state_reg == ST_INIT);
   assign run         = ~init_active;
   assign clr_addr    = clr_cnt_reg;

   // The counter parks on the last word; the state change ends the sweep.
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (init_active) begin
         if (clr_cnt_reg == LAST_ADDR) begin
            state_next = ST_RUN;
         end else begin
            clr_cnt_next = clr_cnt_reg + ADDRW'(1);
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_reg   <= ST_INIT;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end
`else
   localparam int unused_depth = DEPTH;

   assign init_active = 1'b0;
   assign run         = 1'b1;
   assign clr_addr    = '0;
`endif

   // A tie goes to whichever client was not served last.
   assign gnt[0] = run & req[0] & (~req[1] | last_reg);
   assign gnt[1] = run & req[1] & (~req[0] | ~last_reg);
   assign accept = |gnt;
   assign sel    = gnt[1];

   always_comb begin
      nce_next  = 1'b1;
      nwrt_next = 1'b1;
      addr_next = addr_reg;
      din_next  = din_reg;
      last_next = last_reg;
      if (init_active) begin
         nce_next  = 1'b0;
         nwrt_next = 1'b0;
         addr_next = clr_addr;
         din_next  = '0;
      end else if (accept) begin
         nce_next  = 1'b0;
         nwrt_next = ~wr[sel];
         addr_next = addr_sel[sel];
         din_next  = din_sel[sel];
         last_next = sel;
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         nce_reg  <= 1'b1;
         nwrt_reg <= 1'b1;
         addr_reg <= '0;
         din_reg  <= '0;
         last_reg <= 1'b1;
      end else begin
         nce_reg  <= nce_next;
         nwrt_reg <= nwrt_next;
         addr_reg <= addr_next;
         din_reg  <= din_next;
         last_reg <= last_next;
      end
   end

   // Per-client read tag: stage 0 marks the pin cycle, stage 1 the cycle iDO is valid.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ret
         logic [1:0] pipe_reg;
         always_ff @(posedge iClk or negedge iRstn) begin
            if (!iRstn) begin
               pipe_reg <= '0;
            end else begin
               pipe_reg <= {pipe_reg[0], gnt[gi] & ~wr[gi]};
            end
         end
         assign rvalid[gi] = pipe_reg[1];
      end
   endgenerate

   assign oGntA     = gnt[0];
   assign oGntB     = gnt[1];
   assign oRvalidA  = rvalid[0];
   assign oRvalidB  = rvalid[1];
   assign oRdata    = iDO;
   assign oInitDone = run;
   assign oNCE      = nce_reg;
   assign oNWRT     = nwrt_reg;
   assign oRA       = addr_reg[ADDRW-1:4];
   assign oCA       = addr_reg[3:0];
   assign oDIN      = din_reg;

endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: drives sram_arb2 against a small SRAM model and a queue-based reference of
// grants, memory contents and read returns; directed scenarios plus a randomized traffic run.
module tb_sram_arb2;
   localparam int ADDRW = 15;
   localparam int WORDW = 96;
   localparam int DEPTH = 32768;

   logic             iClk;
   logic             iRstn;
   logic             reqA, reqB, wrA, wrB;
   logic [ADDRW-1:0] addrA, addrB;
   logic [WORDW-1:0] dinA, dinB;
   logic             oGntA, oGntB, oRvalidA, oRvalidB, oInitDone, oNCE, oNWRT;
   logic [WORDW-1:0] oRdata, oDIN, iDO;
   logic [10:0]      oRA;
   logic [3:0]       oCA;

   sram_arb2 #(.ADDRW(ADDRW), .WORDW(WORDW), .DEPTH(DEPTH)) dut (
      .iClk(iClk), .iRstn(iRstn),
      .iReqA(reqA), .iReqB(reqB), .iWrA(wrA), .iWrB(wrB),
      .iAddrA(addrA), .iAddrB(addrB), .iDinA(dinA), .iDinB(dinB),
      .oGntA(oGntA), .oGntB(oGntB), .oRvalidA(oRvalidA), .oRvalidB(oRvalidB),
      .oRdata(oRdata), .oInitDone(oInitDone), .oNCE(oNCE), .oNWRT(oNWRT),
      .oRA(oRA), .oCA(oCA), .oDIN(oDIN), .iDO(iDO)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   // SRAM macro: captures pins at the rising edge, read data registered.
   bit   [WORDW-1:0] sram_mem [DEPTH];
   logic [WORDW-1:0] do_reg;
   always @(posedge iClk) begin
      if (!oNCE) begin
         if (!oNWRT) sram_mem[{oRA, oCA}] <= oDIN;
         else        do_reg <= sram_mem[{oRA, oCA}];
      end
   end
   assign iDO = do_reg;

   // Reference model: arbitration rule, word store, queue of returns with due cycle.
   typedef struct { logic client; logic [WORDW-1:0] data; int due; } ret_t;
   ret_t             rq[$];
   logic [WORDW-1:0] mem_m [int];
   logic             m_last;
   logic             m_init_done;
   int               cyc = 0;
   int               tests = 0;
   int               fails = 0;

   function automatic logic [1:0] model_grant();
      if (!m_init_done) return 2'b00;
      if (reqA && reqB) return m_last ? 2'b01 : 2'b10;
      return {reqB, reqA};
   endfunction

   task automatic model_apply(input logic [1:0] g);
      logic             c;
      int               a;
      logic [WORDW-1:0] d;
      ret_t             r;
      if (g == 2'b00) return;
      c = g[1];
      a = int'(c ? addrB : addrA);
      if (c ? wrB : wrA) begin
         mem_m[a] = c ? dinB : dinA;
      end else begin
         d = mem_m.exists(a) ? mem_m[a] : '0;
         r.client = c; r.data = d; r.due = cyc + 1;
         rq.push_back(r);
      end
      m_last = c;
   endtask

   task automatic drive(input logic ra, input logic wa, input logic [ADDRW-1:0] aa,
                        input logic [WORDW-1:0] da, input logic rb, input logic wb,
                        input logic [ADDRW-1:0] ab, input logic [WORDW-1:0] db);
      reqA = ra; wrA = wa; addrA = aa; dinA = da;
      reqB = rb; wrB = wb; addrB = ab; dinB = db;
   endtask

   // One clock: grants sampled before the edge, returns sampled at the following falling edge.
   task automatic tick(output logic [1:0] eg, output logic [1:0] og, output logic [1:0] erv,
                       output logic [1:0] orv, output logic [WORDW-1:0] erd,
                       output logic [WORDW-1:0] ord);
      #1;
      eg = model_grant();
      og = {oGntB, oGntA};
      @(posedge iClk);
      cyc++;
      model_apply(eg);
      @(negedge iClk);
      erv = 2'b00;
      erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         erv = rq[0].client ? 2'b10 : 2'b01;
         erd = rq[0].data;
         void'(rq.pop_front());
      end
      orv = {oRvalidB, oRvalidA};
      ord = oRdata;
   endtask

   task automatic test_reset();
      logic exp_done;
`ifdef SRAM_ARB_INIT_EN
      exp_done = 1'b0;
`else
      exp_done = 1'b1;
`endif
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      iRstn = 1'b1;
      #1 iRstn = 1'b0;
      m_last = 1'b1; m_init_done = 1'b0; rq.delete();
      repeat (2) @(negedge iClk);
      tests++; if ({oGntB, oGntA} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b expected 00", {oGntB, oGntA}); end
      tests++; if ({oRvalidB, oRvalidA} !== 2'b00) begin fails++; $display("FAIL rst_rvalid: got %b expected 00", {oRvalidB, oRvalidA}); end
      tests++; if ({oNCE, oNWRT} !== 2'b11) begin fails++; $display("FAIL rst_ctl: got %b expected 11", {oNCE, oNWRT}); end
      tests++; if ({oRA, oCA} !== 15'h0 || oDIN !== '0) begin fails++; $display("FAIL rst_addr_data: got %h/%h expected 0/0", {oRA, oCA}, oDIN); end
      tests++; if (oInitDone !== exp_done) begin fails++; $display("FAIL rst_initdone: got %b expected %b", oInitDone, exp_done); end
`ifndef SRAM_ARB_INIT_EN
      iRstn = 1'b1;
      m_init_done = 1'b1;
`endif
   endtask

`ifdef SRAM_ARB_INIT_EN
   task automatic test_clear_sweep();
      int bad_g = 0;
      int bad_d = 0;
      logic [1:0] eg, og, erv, orv;
      logic [WORDW-1:0] erd, ord;
      logic [ADDRW-1:0] rd_addr [3];
      rd_addr[0] = 15'h0000; rd_addr[1] = 15'h4ABC; rd_addr[2] = 15'h7FFF;
      drive(1, 0, '0, '0, 1, 0, '0, '0);
      iRstn = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         if (oGntA || oGntB) bad_g++;
         if (oInitDone) bad_d++;
         @(negedge iClk);
      end
      tests++; if (bad_g != 0) begin fails++; $display("FAIL sweep_gnt: got %0d granted cycles expected 0", bad_g); end
      tests++; if (bad_d != 0) begin fails++; $display("FAIL sweep_early_done: got %0d cycles expected 0", bad_d); end
      tests++; if (oInitDone !== 1'b1) begin fails++; $display("FAIL sweep_done: got %b expected 1", oInitDone); end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      m_init_done = 1'b1;
      mem_m.delete();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, rd_addr[k], '0, 0, 0, '0, '0);
         tick(eg, og, erv, orv, erd, ord);
         drive(0, 0, '0, '0, 0, 0, '0, '0);
         tick(eg, og, erv, orv, erd, ord);
         tests++; if (orv !== 2'b01 || ord !== '0) begin fails++; $display("FAIL sweep_read %h: got rv=%b data=%h expected rv=01 data=0", rd_addr[k], orv, ord); end
      end
   endtask
`endif

   task automatic test_single_client();
      logic [1:0] eg, og, erv, orv;
      logic [WORDW-1:0] erd, ord;
      drive(1, 1, 15'h1235, 96'hDEAD_BEEF_0123, 0, 0, '0, '0);
      tick(eg, og, erv, orv, erd, ord);
      tests++; if (og !== 2'b01) begin fails++; $display("FAIL single_wr_gnt: got %b expected 01", og); end
      tests++; if (oRA !== 11'h123 || oCA !== 4'h5) begin fails++; $display("FAIL single_addr: got RA=%h CA=%h expected 123/5", oRA, oCA); end
      tests++; if ({oNCE, oNWRT} !== 2'b00 || oDIN !== 96'hDEAD_BEEF_0123) begin fails++; $display("FAIL single_wr_pins: got %b din=%h expected 00 din=deadbeef0123", {oNCE, oNWRT}, oDIN); end
      drive(1, 0, 15'h1235, '0, 0, 0, '0, '0);
      tick(eg, og, erv, orv, erd, ord);
      tests++; if (og !== 2'b01 || {oNCE, oNWRT} !== 2'b01 || orv !== 2'b00) begin fails++; $display("FAIL single_rd_issue: got gnt=%b ctl=%b rv=%b expected 01/01/00", og, {oNCE, oNWRT}, orv); end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      tick(eg, og, erv, orv, erd, ord);
      tests++; if (orv !== 2'b01 || ord !== 96'hDEAD_BEEF_0123) begin fails++; $display("FAIL single_rd_ret: got rv=%b data=%h expected 01/deadbeef0123", orv, ord); end
      tick(eg, og, erv, orv, erd, ord);
      tests++; if (orv !== 2'b00) begin fails++; $display("FAIL single_rd_pulse: got %b expected 00", orv); end
   endtask

   task automatic test_round_robin();
      logic [1:0] eg, og, erv, orv, want;
      logic [WORDW-1:0] erd, ord, wdat;
      drive(1, 1, 15'h0050, 96'h0A0A, 0, 0, '0, '0);
      tick(eg, og, erv, orv, erd, ord);
      drive(0, 0, '0, '0, 1, 1, 15'h0060, 96'h0B0B);
      tick(eg, og, erv, orv, erd, ord);
      drive(1, 0, 15'h0050, '0, 1, 0, 15'h0060, '0);
      for (int i = 0; i < 8; i++) begin
         if (i == 6) drive(0, 0, '0, '0, 0, 0, '0, '0);
         tick(eg, og, erv, orv, erd, ord);
         if (i < 6) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (og !== want) begin fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, og, want); end
         end
         if (i >= 1 && i <= 6) begin
            want = ((i - 1) % 2 == 0) ? 2'b01 : 2'b10;
            wdat = want[0] ? 96'h0A0A : 96'h0B0B;
            tests++; if (orv !== want || ord !== wdat) begin fails++; $display("FAIL rr_ret[%0d]: got rv=%b data=%h expected %b/%h", i, orv, ord, want, wdat); end
         end else begin
            tests++; if (orv !== 2'b00) begin fails++; $display("FAIL rr_noret[%0d]: got %b expected 00", i, orv); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] eg, og, erv, orv, want;
      logic [WORDW-1:0] erd, ord;
      logic [3:0] exp_nwrt;
      exp_nwrt = 4'b1100;   // bit i = oNWRT after issue i
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       drive(0, 0, '0, '0, 1, 1, 15'h0010, 96'h1);
            1:       drive(0, 0, '0, '0, 1, 1, 15'h0011, 96'h2);
            2:       drive(1, 0, 15'h0010, '0, 0, 0, '0, '0);
            3:       drive(1, 0, 15'h0011, '0, 0, 0, '0, '0);
            default: drive(0, 0, '0, '0, 0, 0, '0, '0);
         endcase
         tick(eg, og, erv, orv, erd, ord);
         if (i < 4) begin
            want = (i < 2) ? 2'b10 : 2'b01;
            tests++; if (og !== want || oNCE !== 1'b0 || oNWRT !== exp_nwrt[i]) begin fails++; $display("FAIL b2b_issue[%0d]: got gnt=%b nce=%b nwrt=%b expected %b/0/%b", i, og, oNCE, oNWRT, want, exp_nwrt[i]); end
         end
         if (i == 3 || i == 4) begin
            tests++; if (orv !== 2'b01 || ord !== WORDW'(i - 2)) begin fails++; $display("FAIL b2b_ret[%0d]: got rv=%b data=%h expected 01/%0d", i, orv, ord, i - 2); end
         end else begin
            tests++; if (orv !== 2'b00) begin fails++; $display("FAIL b2b_noret[%0d]: got %b expected 00", i, orv); end
         end
      end
   endtask

   task automatic test_idle();
      logic [1:0] eg, og, erv, orv;
      logic [WORDW-1:0] erd, ord, keep_d;
      logic [14:0] keep_a;
      drive(0, 0, '0, '0, 1, 1, 15'h0077, 96'h77);
      tick(eg, og, erv, orv, erd, ord);
      keep_a = {oRA, oCA};
      keep_d = oDIN;
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         tick(eg, og, erv, orv, erd, ord);
         tests++; if ({oNCE, oNWRT} !== 2'b11 || orv !== 2'b00 || {oRA, oCA} !== keep_a || oDIN !== keep_d) begin fails++; $display("FAIL idle[%0d]: got ctl=%b rv=%b addr=%h expected 11/00/%h", i, {oNCE, oNWRT}, orv, {oRA, oCA}, keep_a); end
      end
      drive(1, 0, 15'h0077, '0, 1, 0, 15'h0077, '0);
      #1;
      tests++; if ({oGntB, oGntA} !== 2'b01) begin fails++; $display("FAIL idle_last: got %b expected 01", {oGntB, oGntA}); end
      tick(eg, og, erv, orv, erd, ord);
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) begin
         tick(eg, og, erv, orv, erd, ord);
         tests++; if (orv !== erv || (erv != 2'b00 && ord !== erd)) begin fails++; $display("FAIL idle_drain: got rv=%b data=%h expected %b/%h", orv, ord, erv, erd); end
      end
   endtask

   task automatic test_random();
      logic [1:0] eg, og, erv, orv;
      logic [WORDW-1:0] erd, ord;
      logic pa = 1'b0, pb = 1'b0, wa = 1'b0, wb = 1'b0;
      logic [ADDRW-1:0] aa = '0, ab = '0;
      logic [WORDW-1:0] da = '0, db = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pa && $urandom_range(0, 3) != 0) begin
            pa = 1'b1; wa = $urandom_range(0, 1) == 1;
            aa = 15'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 15'h7FF0 : 15'h0);
            da = {$urandom, $urandom, $urandom};
         end
         if (!pb && $urandom_range(0, 3) != 0) begin
            pb = 1'b1; wb = $urandom_range(0, 1) == 1;
            ab = 15'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 15'h7FF0 : 15'h0);
            db = {$urandom, $urandom, $urandom};
         end
         drive(pa, wa, aa, da, pb, wb, ab, db);
         tick(eg, og, erv, orv, erd, ord);
         tests++; if (og !== eg || og === 2'b11) begin fails++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", i, og, eg); end
         tests++; if (orv !== erv || (erv != 2'b00 && ord !== erd)) begin fails++; $display("FAIL rnd_ret[%0d]: got rv=%b data=%h expected %b/%h", i, orv, ord, erv, erd); end
         if (eg[0]) pa = 1'b0;
         if (eg[1]) pb = 1'b0;
      end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) begin
         tick(eg, og, erv, orv, erd, ord);
         tests++; if (orv !== erv || (erv != 2'b00 && ord !== erd)) begin fails++; $display("FAIL rnd_drain: got rv=%b data=%h expected %b/%h", orv, ord, erv, erd); end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] eg, og, erv, orv;
      logic [WORDW-1:0] erd, ord;
      drive(1, 0, 15'h0050, '0, 0, 0, '0, '0);
      tick(eg, og, erv, orv, erd, ord);
      tests++; if (og !== 2'b01 || oNCE !== 1'b0) begin fails++; $display("FAIL midrst_accept: got gnt=%b nce=%b expected 01/0", og, oNCE); end
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      iRstn = 1'b0;
      rq.delete(); m_last = 1'b1;
`ifdef SRAM_ARB_INIT_EN
      m_init_done = 1'b0;
`endif
      #1;
      tests++; if ({oNCE, oNWRT} !== 2'b11 || {oRA, oCA} !== 15'h0 || oDIN !== '0) begin fails++; $display("FAIL midrst_async: got ctl=%b addr=%h din=%h expected 11/0/0", {oNCE, oNWRT}, {oRA, oCA}, oDIN); end
      @(negedge iClk);
      tests++; if ({oRvalidB, oRvalidA} !== 2'b00 || {oGntB, oGntA} !== 2'b00) begin fails++; $display("FAIL midrst_hold: got rv=%b gnt=%b expected 00/00", {oRvalidB, oRvalidA}, {oGntB, oGntA}); end
      iRstn = 1'b1;
`ifdef SRAM_ARB_INIT_EN
      for (int i = 0; i < DEPTH + 8 && !oInitDone; i++) @(negedge iClk);
      tests++; if (oInitDone !== 1'b1) begin fails++; $display("FAIL midrst_sweep: got %b expected 1", oInitDone); end
      m_init_done = 1'b1;
      mem_m.delete();
`endif
      repeat (3) begin
         tick(eg, og, erv, orv, erd, ord);
         tests++; if (orv !== 2'b00 || {oNCE, oNWRT} !== 2'b11) begin fails++; $display("FAIL midrst_after: got rv=%b ctl=%b expected 00/11", orv, {oNCE, oNWRT}); end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
`ifdef SRAM_ARB_INIT_EN
      test_clear_sweep();
`endif
      test_single_client();
      test_round_robin();
      test_back_to_back();
      test_idle();
      test_random();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
